sm_stream_accumulator: RTL and testbench
========================================

// Module: sm_stream_accumulator
// PURPOSE
//  Downstream consumer of the signed ripple-carry adder's sign-magnitude sums.
//  Accumulates a packet of sign-magnitude words (MSB = sign, rest = magnitude)
//  into one running total and emits the total once, on the packet's last word.
//  Handshakes are valid/ready on both sides. Overflow saturates the total and
//  sets a sticky flag.
// PARAMETERS
//  WIDTH    32  word width incl. sign bit; magnitude is WIDTH-1 bits
//  COUNT_W  8   width of the accepted-word counter
// PORTS
//  clk           in   1        single clock, all state updates on rising edge
//  rst           in   1        synchronous, active-high reset
//  clear         in   1        synchronous abort of the current packet
//  in_valid      in   1        in_data/in_last valid
//  in_ready      out  1        block can accept a word this cycle
//  in_data       in   WIDTH    sign-magnitude operand
//  in_last       in   1        marks the final word of the packet
//  out_valid     out  1        out_* hold the final packet result
//  out_ready     in   1        downstream accepts the result
//  out_data      out  WIDTH    sign-magnitude total
//  out_count     out  COUNT_W  words accepted in the packet, saturating
//  out_overflow  out  1        the total saturated during the packet
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; acc=+0; count=0; ovf=0;
//    out_valid=0; out_data=0; out_count=0; out_overflow=0.
//  - Priority: rst > clear > handshakes. clear in any state behaves as reset
//    and drops any pending result.
//  - States:
//    IDLE: in_ready=1. An accepted word loads acc. If in_last=1, go to HOLD,
//          else go to ACC.
//    ACC:  in_ready=1. An accepted word adds into acc. If in_last=1, go to
//          HOLD, else stay in ACC.
//    HOLD: in_ready=0; out_valid=1. When out_ready=1, go to IDLE and clear
//          acc/count/ovf.
//  - Word accepted = in_valid & in_ready.
//  - Latency: last word accepted at edge N gives out_valid=1 from edge N
//    onward (registered). out_* stay stable while out_valid & !out_ready.
//  - Sign-magnitude add, acc + x:
//    - Same signs: magnitudes add and the sign is kept.
//    - Different signs: the larger magnitude minus the smaller, with the
//      larger magnitude's sign. Equal magnitudes give +0.
//  - Negative zero (sign=1, mag=0) is normalised to +0, both on input and on
//    output. out_data never carries 0x8000_0000 for WIDTH=32.
//  - Saturation: if the magnitude sum exceeds 2^(WIDTH-1)-1, the magnitude
//    clamps to 2^(WIDTH-1)-1, the sign is kept, and ovf=1 (sticky until the
//    packet ends). Later words keep adding to the clamped value.
//  - count increments per accepted word and saturates at 2^COUNT_W-1.
//  - in_data is ignored when in_valid=0. in_last without in_valid is ignored.
//  - A single-word packet (in_last on the first word) emits that word,
//    normalised, with count=1.
// TESTING
//  1. Words {0x8000_0001, 0x0000_0001}, last on word 2 -> out_data=0x0000_0000,
//     count=2, ovf=0.
//  2. Words {10, 5} -> out_data=0x0000_000F. Words {0x8000_000A, 5} ->
//     0x8000_0005. Words {0x8000_000A, 0x8000_0005} -> 0x8000_000F.
//  3. Words {0x7FFF_FFFF, 1, 0x8000_0003} -> out_data=0x7FFF_FFFC,
//     out_overflow=1, count=3.
//  4. Hold out_ready=0 for 5 cycles after the result -> out_* stable,
//     in_ready=0, in_valid words not accepted. Then out_ready=1 -> IDLE next
//     cycle, in_ready=1.
//  5. Assert rst or clear after 2 words of a packet, then send {7} with last
//     -> out_data=7, count=1, ovf=0.
//  6. Single word 0x8000_0000 with last -> out_data=0x0000_0000, count=1.
//     With COUNT_W=2, send 5 words -> count=3.

Source files
------------

// File: rtl/sm_stream_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sm_stream_accumulator
// Brief   : Sums a packet of sign-magnitude words, emits one saturated total.
// Revision: 1.0 - initial release
// ============================================================================
module sm_stream_accumulator #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_overflow
);

    localparam int MAG_W = WIDTH - 1;
    localparam logic [MAG_W-1:0] c_mag_max = {MAG_W{1'b1}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_acc_sign;
    logic [MAG_W-1:0]   r_acc_mag;
    logic [COUNT_W-1:0] r_count;
    logic               r_ovf;

    logic               w_accept;
    logic               w_in_sign;
    logic [MAG_W-1:0]   w_in_mag;
    logic               w_base_sign;
    logic [MAG_W-1:0]   w_base_mag;
    logic [MAG_W:0]     w_mag_add;
    logic               w_sum_sign;
    logic [MAG_W-1:0]   w_sum_mag;
    logic               w_sum_ovf;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               w_ovf_nxt;

    assign w_accept = in_valid & in_ready;
    assign w_in_mag = in_data[MAG_W-1:0];
    // Negative zero on the input is treated as +0.
    assign w_in_sign = in_data[WIDTH-1] & (|w_in_mag);

    // The first word of a packet adds onto +0, which is the same as loading it.
    assign w_base_sign = (r_state == c_st_idle) ? 1'b0 : r_acc_sign;
    assign w_base_mag  = (r_state == c_st_idle) ? '0   : r_acc_mag;

    always_comb begin
        w_mag_add  = {1'b0, w_base_mag} + {1'b0, w_in_mag};
        w_sum_sign = w_base_sign;
        w_sum_mag  = w_mag_add[MAG_W-1:0];
        w_sum_ovf  = 1'b0;
        if (w_base_sign == w_in_sign) begin
            if (w_mag_add[MAG_W]) begin
                w_sum_mag = c_mag_max;
                w_sum_ovf = 1'b1;
            end
        end else if (w_base_mag >= w_in_mag) begin
            w_sum_mag  = w_base_mag - w_in_mag;
            w_sum_sign = w_base_sign;
        end else begin
            w_sum_mag  = w_in_mag - w_base_mag;
            w_sum_sign = w_in_sign;
        end
        if (w_sum_mag == '0) begin
            w_sum_sign = 1'b0;
        end
    end

    always_comb begin
        if (r_state == c_st_idle) begin
            w_count_nxt = COUNT_W'(1);
            w_ovf_nxt   = w_sum_ovf;
        end else begin
            w_count_nxt = (&r_count) ? r_count : r_count + 1'b1;
            w_ovf_nxt   = r_ovf | w_sum_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_acc: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? c_st_hold : c_st_acc;
                end
            end
            c_st_hold: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_count    = '0;
        out_overflow = 1'b0;
        case (r_state)
            c_st_idle, c_st_acc: in_ready = 1'b1;
            c_st_hold: begin
                out_valid    = 1'b1;
                out_data     = {r_acc_sign, r_acc_mag};
                out_count    = r_count;
                out_overflow = r_ovf;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc_sign <= 1'b0;
            r_acc_mag  <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_acc_sign <= w_sum_sign;
            r_acc_mag  <= w_sum_mag;
            r_count    <= w_count_nxt;
            r_ovf      <= w_ovf_nxt;
        end else if ((r_state == c_st_hold) && out_ready) begin
            r_acc_sign <= 1'b0;
            r_acc_mag  <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_stream_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sm_stream_accumulator
// Brief   : Scoreboard bench for sm_stream_accumulator (two COUNT_W settings).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sm_stream_accumulator;

    localparam longint MAXMAG = 64'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_overflow;
    logic [31:0] out_data;
    logic [7:0]  out_count;
    logic        in_ready2, out_valid2, out_overflow2;
    logic [31:0] out_data2;
    logic [1:0]  out_count2;

    always #5 clk = ~clk;

    sm_stream_accumulator #(.WIDTH(32), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    sm_stream_accumulator #(.WIDTH(32), .COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_count(out_count2), .out_overflow(out_overflow2)
    );

    typedef struct {
        logic [31:0] data;
        int          cnt;
        int          cnt2;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] words[$];
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;   // 0 random, 1 hold low, 2 hold high

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed integer sum clamped to +/-MAXMAG, then re-encoded.
    function automatic longint to_int(input logic [31:0] w);
        return w[31] ? -longint'(w[30:0]) : longint'(w[30:0]);
    endfunction

    function automatic logic [31:0] from_int(input longint v);
        return (v < 0) ? {1'b1, 31'(-v)} : {1'b0, 31'(v)};
    endfunction

    task automatic model_packet(output exp_t e);
        longint acc = 0;
        logic   ovf = 1'b0;
        foreach (words[i]) begin
            acc = acc + to_int(words[i]);
            if (acc > MAXMAG)  begin acc = MAXMAG;  ovf = 1'b1; end
            if (acc < -MAXMAG) begin acc = -MAXMAG; ovf = 1'b1; end
        end
        e.data = from_int(acc);
        e.cnt  = (words.size() > 255) ? 255 : words.size();
        e.cnt2 = (words.size() > 3) ? 3 : words.size();
        e.ovf  = ovf;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom % 4)
            0:       return {1'($urandom), 31'($urandom % 16)};
            1:       return {1'($urandom), 31'h7FFF_FFFF - 31'($urandom % 8)};
            2:       return $urandom;
            default: return {1'($urandom), 31'd0};
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input logic [31:0] w, input logic last);
        int t = 0;
        repeat ($urandom % 3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_words(input logic with_last);
        foreach (words[i]) send_word(words[i], with_last && (i == words.size() - 1));
    endtask

    task automatic send_pkt(input logic [31:0] ed, input int ec, input logic eo);
        exp_t e;
        e.data = ed;
        e.cnt  = (ec > 255) ? 255 : ec;
        e.cnt2 = (ec > 3) ? 3 : ec;
        e.ovf  = eo;
        sb.push_back(e);
        send_words(1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: out_ready is set for the coming edge, then a handshake is scored.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = ($urandom % 3) != 0;
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out_data=0x%0h expected no result", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_count", out_count, e.cnt);
                    check("out_overflow", out_overflow, e.ovf);
                    check("out_valid2", out_valid2, 1);
                    check("out_data2", out_data2, e.data);
                    check("out_count2", out_count2, e.cnt2);
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_overflow", out_overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        words = '{32'h8000_0001, 32'h0000_0001}; send_pkt(32'h0, 2, 1'b0);
        words = '{32'd10, 32'd5};                send_pkt(32'h0000_000F, 2, 1'b0);
        words = '{32'h8000_000A, 32'd5};         send_pkt(32'h8000_0005, 2, 1'b0);
        words = '{32'h8000_000A, 32'h8000_0005}; send_pkt(32'h8000_000F, 2, 1'b0);
        words = '{32'h7FFF_FFFF, 32'd1, 32'h8000_0003}; send_pkt(32'h7FFF_FFFC, 3, 1'b1);
        words = '{32'h8000_0000};                send_pkt(32'h0, 1, 1'b0);
        words = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1}; send_pkt(32'd5, 5, 1'b0);
        words.delete();
        for (int i = 0; i < 260; i++) words.push_back(32'h8000_0000);
        send_pkt(32'h0, 260, 1'b0);

        // Stalled result: outputs hold, no word is accepted.
        drain();
        ready_mode = 1;
        words = '{32'd10, 32'd5}; send_pkt(32'h0000_000F, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h63; in_last = 1'b1;
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 32'h0000_000F);
            check("stall_out_count", out_count, 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        ready_mode = 2;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        ready_mode = 0;

        // Abort mid-packet with rst, then with clear.
        for (int k = 0; k < 2; k++) begin
            drain();
            words = '{32'd100, 32'h7FFF_FFFF};
            send_words(1'b0);
            if (k == 0) rst = 1'b1; else clear = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; clear = 1'b0;
            words = '{32'd7}; send_pkt(32'd7, 1, 1'b0);
        end

        for (int p = 0; p < 150; p++) begin
            int len = 1 + ($urandom % 8);
            words.delete();
            for (int i = 0; i < len; i++) words.push_back(rand_word());
            model_packet(e);
            sb.push_back(e);
            send_words(1'b1);
        end

        drain();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
